// File: rtl/aes_dfa_campaign.sv
// aes_dfa_campaign: runs one fault-free encryption on an external faultable
// AES core, then a sweep of single-bit fault runs, buffers every faulty
// ciphertext and drains the buffer through a valid/ready port.
module aes_dfa_campaign #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned CORE_LAT = 21,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [127:0]     pt,
  input  logic [127:0]     key,
  input  logic [6:0]       first_bit,
  input  logic [6:0]       stride,
  input  logic [CNT_W-1:0] num_faults,
  output logic [127:0]     core_state,
  output logic [127:0]     core_key,
  output logic             core_fault_en,
  output logic [6:0]       core_fault_bit,
  input  logic [127:0]     core_ct,
  output logic [127:0]     golden,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [127:0]     rd_data,
  output logic [6:0]       rd_bit,
  output logic             rd_diff,
  output logic             busy,
  output logic             done,
  output logic             clamp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned LAT_W = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GOLD  = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]       state, state_n;
  logic [LAT_W-1:0] cnt, cnt_n;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
  logic [PTR_W-1:0] eff_q;
  logic [6:0]       first_bit_q;
  logic [6:0]       stride_q;

  logic             accept, golden_ld, wr_en, done_n, rd_valid_n;
  logic             rd_load, rd_clear, lat_last, rd_fire;
  logic             fault_en_n;
  logic [6:0]       fault_bit_n;

  logic             clamp_c;
  logic [PTR_W-1:0] eff_c;
  logic             diff_c;
  logic             byp_c;

  logic [127:0]     buf_ct   [DEPTH];
  logic [6:0]       buf_bit  [DEPTH];
  logic             buf_diff [DEPTH];

  // Effective fault count, clamped to the buffer size
  assign clamp_c = (32'(num_faults) > DEPTH);
  assign eff_c   = clamp_c ? PTR_W'(DEPTH) : PTR_W'(num_faults);
  assign diff_c  = (core_ct != golden);
  assign byp_c   = wr_en && (wr_ptr[IDX_W-1:0] == rd_ptr_n[IDX_W-1:0]);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state and control decode
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    wr_ptr_n    = wr_ptr;
    rd_ptr_n    = rd_ptr;
    accept      = 1'b0;
    golden_ld   = 1'b0;
    wr_en       = 1'b0;
    done_n      = 1'b0;
    rd_valid_n  = rd_valid;
    rd_load     = 1'b0;
    rd_clear    = 1'b0;
    fault_en_n  = core_fault_en;
    fault_bit_n = core_fault_bit;
    lat_last    = (cnt == LAT_W'(CORE_LAT - 1));
    rd_fire     = rd_valid && rd_ready;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_n    = S_GOLD;
          cnt_n      = '0;
          wr_ptr_n   = '0;
          rd_ptr_n   = '0;
          fault_en_n = 1'b0;
        end
      end
      S_GOLD: begin
        if (lat_last) begin
          golden_ld = 1'b1;
          cnt_n     = '0;
          if (eff_q != PTR_W'(0)) begin
            state_n     = S_FAULT;
            fault_en_n  = 1'b1;
            fault_bit_n = first_bit_q;
          end else begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt + LAT_W'(1);
        end
      end
      S_FAULT: begin
        if (lat_last) begin
          wr_en       = 1'b1;
          cnt_n       = '0;
          wr_ptr_n    = wr_ptr + PTR_W'(1);
          fault_bit_n = core_fault_bit + stride_q;
          if (wr_ptr_n == eff_q) begin
            state_n    = S_DRAIN;
            fault_en_n = 1'b0;
            rd_ptr_n   = '0;
            rd_valid_n = 1'b1;
            rd_load    = 1'b1;
          end
        end else begin
          cnt_n = cnt + LAT_W'(1);
        end
      end
      default: begin
        if (rd_fire) begin
          rd_ptr_n = rd_ptr + PTR_W'(1);
          if (rd_ptr_n == eff_q) begin
            state_n    = S_IDLE;
            done_n     = 1'b1;
            rd_valid_n = 1'b0;
            rd_clear   = 1'b1;
          end else begin
            rd_load = 1'b1;
          end
        end
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      eff_q          <= '0;
      first_bit_q    <= '0;
      stride_q       <= '0;
      core_state     <= '0;
      core_key       <= '0;
      core_fault_en  <= 1'b0;
      core_fault_bit <= '0;
      golden         <= '0;
      rd_valid       <= 1'b0;
      rd_data        <= '0;
      rd_bit         <= '0;
      rd_diff        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      clamp_err      <= 1'b0;
    end else begin
      cnt            <= cnt_n;
      wr_ptr         <= wr_ptr_n;
      rd_ptr         <= rd_ptr_n;
      core_fault_en  <= fault_en_n;
      core_fault_bit <= fault_bit_n;
      rd_valid       <= rd_valid_n;
      done           <= done_n;
      busy           <= (state_n != S_IDLE);
      if (accept) begin
        core_state  <= pt;
        core_key    <= key;
        first_bit_q <= first_bit;
        stride_q    <= stride;
        eff_q       <= eff_c;
        clamp_err   <= clamp_c;
      end
      if (golden_ld) golden <= core_ct;
      if (rd_clear) begin
        rd_data <= '0;
        rd_bit  <= '0;
        rd_diff <= 1'b0;
      end else if (rd_load) begin
        if (byp_c) begin
          rd_data <= core_ct;
          rd_bit  <= core_fault_bit;
          rd_diff <= diff_c;
        end else begin
          rd_data <= buf_ct[rd_ptr_n[IDX_W-1:0]];
          rd_bit  <= buf_bit[rd_ptr_n[IDX_W-1:0]];
          rd_diff <= buf_diff[rd_ptr_n[IDX_W-1:0]];
        end
      end
    end
  end

  // Capture buffer; contents are only meaningful below the write pointer
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_ct[wr_ptr[IDX_W-1:0]]   <= core_ct;
      buf_bit[wr_ptr[IDX_W-1:0]]  <= core_fault_bit;
      buf_diff[wr_ptr[IDX_W-1:0]] <= diff_c;
    end
  end

endmodule

// File: tb/tb_aes_dfa_campaign.sv
// Bench for aes_dfa_campaign: behavioural AES-128 core with a bit-flip
// fault before the last round, plus a campaign-level reference model.
module tb_aes_dfa_campaign;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned CORE_LAT = 21;
  localparam int unsigned CNT_W    = 8;
  localparam logic [127:0] JUNK    = 128'h0bad_f00d_dead_beef_0bad_f00d_dead_beef;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [127:0]     pt, key;
  logic [6:0]       first_bit, stride;
  logic [CNT_W-1:0] num_faults;
  logic [127:0]     core_state, core_key, core_ct, golden, rd_data;
  logic             core_fault_en, rd_valid, rd_ready, rd_diff, busy, done, clamp_err;
  logic [6:0]       core_fault_bit, rd_bit;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aes_dfa_campaign #(.DEPTH(DEPTH), .CORE_LAT(CORE_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pt(pt), .key(key),
    .first_bit(first_bit), .stride(stride), .num_faults(num_faults),
    .core_state(core_state), .core_key(core_key), .core_fault_en(core_fault_en),
    .core_fault_bit(core_fault_bit), .core_ct(core_ct), .golden(golden),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_bit(rd_bit),
    .rd_diff(rd_diff), .busy(busy), .done(done), .clamp_err(clamp_err)
  );

  // ---------------- AES-128 reference ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] r, p, e;
    r = 8'h01; p = a; e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gm(r, p);
      p = gm(p, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [127:0] k,
                                           input logic fen, input logic [6:0] fbit);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] st;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    st = p ^ {w[0], w[1], w[2], w[3]};
    for (int rnd = 1; rnd <= 10; rnd++) begin
      if (rnd == 10 && fen) st[fbit] = ~st[fbit];
      for (int i = 0; i < 16; i++) s[i] = sb(st[127-8*i -: 8]);
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++) t[row + 4*c] = s[row + 4*((c + row) % 4)];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = t[i];
      st = st ^ {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
    end
    return st;
  endfunction

  // ---------------- Core model: valid only after CORE_LAT stable cycles ----------------
  logic [127:0] last_state, last_key, aes_val;
  logic         last_en;
  logic [6:0]   last_bit;
  int           age_reg = 0;
  int           age_now;

  always_comb begin
    if (core_state == last_state && core_key == last_key &&
        core_fault_en == last_en && core_fault_bit == last_bit)
      age_now = (age_reg < 1000) ? age_reg + 1 : age_reg;
    else
      age_now = 1;
  end

  always_comb aes_val = aes_enc(core_state, core_key, core_fault_en, core_fault_bit);
  assign core_ct = (age_now >= int'(CORE_LAT)) ? aes_val : JUNK;

  always @(posedge clk) begin
    last_state <= core_state;
    last_key   <= core_key;
    last_en    <= core_fault_en;
    last_bit   <= core_fault_bit;
    age_reg    <= age_now;
  end

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- Stimulus helpers ----------------
  task automatic launch(input logic [127:0] p, input logic [127:0] k, input logic [6:0] fb,
                        input logic [6:0] sd, input logic [CNT_W-1:0] nf);
    @(negedge clk);
    pt = p; key = k; first_bit = fb; stride = sd; num_faults = nf;
    start = 1'b1; rd_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    pt = r128(); key = r128();
    first_bit = 7'($urandom); stride = 7'($urandom); num_faults = CNT_W'($urandom);
  endtask

  // One complete campaign checked against the reference model
  task automatic campaign(input string tag, input logic [127:0] p, input logic [127:0] k,
                          input logic [6:0] fb, input logic [6:0] sd,
                          input logic [CNT_W-1:0] nf, input int pct, input bit poke);
    logic [127:0] g_m, prev_d;
    logic [6:0]   prev_b, b;
    logic [127:0] e_ct [$];
    logic [6:0]   e_bit [$];
    bit           clamp_m, hs, prev_stall;
    int           eff, cycles, got, guard;
    g_m     = aes_enc(p, k, 1'b0, 7'd0);
    clamp_m = (int'(nf) > int'(DEPTH));
    eff     = clamp_m ? int'(DEPTH) : int'(nf);
    for (int i = 0; i < eff; i++) begin
      b = 7'((int'(fb) + i * int'(sd)) % 128);
      e_bit.push_back(b);
      e_ct.push_back(aes_enc(p, k, 1'b1, b));
    end

    launch(p, k, fb, sd, nf);
    n_checks++;
    if ({busy, core_state, core_key, core_fault_en} !== {1'b1, p, k, 1'b0}) begin
      n_fail++;
      $display("FAIL %s launch: busy=%b state=%h key=%h fen=%b required busy=1 state=%h key=%h fen=0",
               tag, busy, core_state, core_key, core_fault_en, p, k);
    end
    n_checks++;
    if (clamp_err !== clamp_m) begin
      n_fail++;
      $display("FAIL %s clamp_err: got %b required %b", tag, clamp_err, clamp_m);
    end

    cycles = 0;
    while (!(rd_valid || done) && cycles < 50000) begin
      if (poke && cycles == 5) begin
        start = 1'b1; pt = r128(); key = r128();
        first_bit = 7'($urandom); stride = 7'($urandom); num_faults = CNT_W'($urandom);
      end else start = 1'b0;
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    n_checks++;
    if (cycles != (1 + eff) * int'(CORE_LAT)) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles required %0d", tag, cycles, (1 + eff) * int'(CORE_LAT));
    end
    n_checks++;
    if (golden !== g_m) begin
      n_fail++;
      $display("FAIL %s golden: got %h required %h", tag, golden, g_m);
    end

    if (eff == 0) begin
      n_checks++;
      if ({done, busy, rd_valid} !== 3'b100) begin
        n_fail++;
        $display("FAIL %s no_fault_end: done,busy,rd_valid=%b required 100", tag, {done, busy, rd_valid});
      end
      @(posedge clk); #1;
      n_checks++;
      if ({done, rd_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL %s done_pulse: done,rd_valid=%b required 00", tag, {done, rd_valid});
      end
      return;
    end

    n_checks++;
    if ({rd_valid, done, core_fault_en} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s drain_entry: rd_valid,done,fen=%b required 100", tag, {rd_valid, done, core_fault_en});
    end

    got = 0; guard = 0; prev_stall = 1'b0; prev_d = '0; prev_b = '0;
    while (got < eff && guard < 20000) begin
      @(negedge clk);
      guard++;
      n_checks++;
      if ({rd_valid, rd_data, rd_bit, rd_diff} !== {1'b1, e_ct[got], e_bit[got], e_ct[got] != g_m}) begin
        n_fail++;
        $display("FAIL %s entry%0d: valid=%b data=%h bit=%0d diff=%b required valid=1 data=%h bit=%0d diff=%b",
                 tag, got, rd_valid, rd_data, rd_bit, rd_diff, e_ct[got], e_bit[got], e_ct[got] != g_m);
      end
      if (prev_stall) begin
        n_checks++;
        if ({rd_data, rd_bit} !== {prev_d, prev_b}) begin
          n_fail++;
          $display("FAIL %s stall_hold: data=%h bit=%0d required data=%h bit=%0d",
                   tag, rd_data, rd_bit, prev_d, prev_b);
        end
      end
      prev_d = rd_data; prev_b = rd_bit;
      rd_ready = ($urandom_range(99) < pct);
      if (poke && got == 1) begin
        start = 1'b1; pt = r128(); key = r128(); num_faults = CNT_W'($urandom);
      end else start = 1'b0;
      hs = rd_valid && rd_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) got++;
      prev_stall = !hs;
    end
    rd_ready = 1'b0;
    n_checks++;
    if (got != eff) begin
      n_fail++;
      $display("FAIL %s drain_timeout: drained %0d required %0d", tag, got, eff);
    end
    n_checks++;
    if ({done, busy, rd_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s final_handshake: done,busy,rd_valid=%b required 100", tag, {done, busy, rd_valid});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({done, busy, rd_valid, core_state, core_key} !== {3'b000, p, k}) begin
      n_fail++;
      $display("FAIL %s idle_after: done,busy,rd_valid=%b state=%h key=%h required 000 state=%h key=%h",
               tag, {done, busy, rd_valid}, core_state, core_key, p, k);
    end
  endtask

  // ---------------- Scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b1; pt = r128(); key = r128(); num_faults = CNT_W'($urandom);
      first_bit = 7'($urandom); stride = 7'($urandom); rd_ready = 1'($urandom);
      n_checks++;
      if ({core_state, core_key, core_fault_en, core_fault_bit, golden, rd_valid, rd_data,
           rd_bit, rd_diff, busy, done, clamp_err} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: busy=%b done=%b rd_valid=%b state=%h golden=%h required all zero",
                 busy, done, rd_valid, core_state, golden);
      end
    end
    @(negedge clk);
    start = 1'b0; rd_ready = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({core_state, core_key, core_fault_en, core_fault_bit, golden, rd_valid, rd_data,
         rd_bit, rd_diff, busy, done, clamp_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_exit: busy=%b done=%b rd_valid=%b state=%h golden=%h required all zero",
               busy, done, rd_valid, core_state, golden);
    end
  endtask

  task automatic test_golden_only();
    campaign("golden_only", 128'h97157a6fc8e4bbe432c40d35f2716092,
             128'heba02e379817d636a144551df49ade37, 7'd5, 7'd9, CNT_W'(0), 100, 1'b0);
  endtask

  task automatic test_fault_sweep();
    campaign("fault_sweep", 128'h97157a6fc8e4bbe432c40d35f2716092,
             128'heba02e379817d636a144551df49ade37, 7'd120, 7'd3, CNT_W'(4), 100, 1'b0);
  endtask

  task automatic test_clamp();
    campaign("clamp", r128(), r128(), 7'($urandom), 7'($urandom), CNT_W'(DEPTH + 5), 70, 1'b0);
  endtask

  task automatic test_random_ready();
    for (int n = 0; n < 3; n++)
      campaign("random_ready", r128(), r128(), 7'($urandom), 7'($urandom),
               CNT_W'($urandom_range(1, DEPTH)), 40, 1'b0);
  endtask

  task automatic test_reset_mid_fault();
    logic [127:0] p, k;
    logic [6:0]   fb, sd, b2;
    p = r128(); k = r128(); fb = 7'($urandom); sd = 7'($urandom_range(1, 127));
    b2 = 7'((int'(fb) + 2 * int'(sd)) % 128);
    launch(p, k, fb, sd, CNT_W'(8));
    repeat (3 * CORE_LAT + 4) @(posedge clk);
    #2;
    n_checks++;
    if ({core_fault_en, core_fault_bit, busy} !== {1'b1, b2, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_fault_run2: fen=%b bit=%0d busy=%b required fen=1 bit=%0d busy=1",
               core_fault_en, core_fault_bit, busy, b2);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({core_state, core_key, core_fault_en, core_fault_bit, golden, rd_valid, rd_data,
         rd_bit, rd_diff, busy, done, clamp_err} !== '0) begin
      n_fail++;
      $display("FAIL mid_fault_reset: busy=%b fen=%b state=%h golden=%h required all zero",
               busy, core_fault_en, core_state, golden);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, rd_valid, core_fault_en, golden} !== '0) begin
      n_fail++;
      $display("FAIL mid_fault_exit: busy=%b done=%b rd_valid=%b fen=%b golden=%h required all zero",
               busy, done, rd_valid, core_fault_en, golden);
    end
    campaign("after_reset", r128(), r128(), 7'($urandom), 7'($urandom), CNT_W'(5), 60, 1'b0);
  endtask

  task automatic test_start_ignored();
    campaign("start_ignored", r128(), r128(), 7'($urandom), 7'($urandom), CNT_W'(6), 50, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; rd_ready = 1'b0;
    pt = '0; key = '0; first_bit = '0; stride = '0; num_faults = '0;
    if (aes_enc(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                1'b0, 7'd0) !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
      $display("FAIL model_kat: reference AES model is wrong");
      $fatal(1, "model");
    end
    test_reset();
    test_golden_only();
    test_fault_sweep();
    test_clamp();
    test_random_ready();
    test_reset_mid_fault();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
